// File: rtl/qf_sff_pkr_pkg.sv
// Shared types and constants for the qf_sff write-side byte packer.
package qf_sff_pkr_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_PUSH = 1'b1
    } pkr_state_t;

    localparam int BYTE_W     = 8;
    localparam int WORD_CNT_W = 16;

endpackage

// File: rtl/qf_sff_pkr.sv
// Byte-to-word packer in front of qf_sff: little-endian assembly, FIFO push, zero-padded flush.
// Optional push counter output word_cnt when QF_SFF_PKR_WORD_CNT_EN is defined.
module qf_sff_pkr
    import qf_sff_pkr_pkg::*;
#(
    parameter int PAR_WORD_BYTES = 4
) (
    input  logic                             pkr_clk,
    input  logic                             pkr_rst,
    input  logic [BYTE_W-1:0]                byte_data,
    input  logic                             byte_valid,
    output logic                             byte_ready,
    input  logic                             flush_req,
    output logic                             flush_done,
    output logic                             busy,
    output logic                             fifo_wr_en,
    output logic [BYTE_W*PAR_WORD_BYTES-1:0] fifo_wr_data,
    input  logic                             fifo_full_flag
`ifdef QF_SFF_PKR_WORD_CNT_EN
    ,
    output logic [WORD_CNT_W-1:0]            word_cnt
`endif
);

    localparam int WORD_W = BYTE_W * PAR_WORD_BYTES;
    localparam int IDX_W  = $clog2(PAR_WORD_BYTES) + 1;
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PAR_WORD_BYTES);

    pkr_state_t        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic              flush_pend_q, flush_pend_d;
    logic              flush_done_q, flush_done_d;
    logic              accept;
    logic              push;

    assign accept = byte_valid && (state_q == ST_FILL);
    // fifo_full_flag is registered inside qf_sff, so gating the write on it is loop-free.
    assign push   = (state_q == ST_PUSH) && !fifo_full_flag;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        flush_pend_d = flush_pend_q;
        flush_done_d = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    for (int i = 0; i < PAR_WORD_BYTES; i++) begin
                        if (byte_idx_q == IDX_W'(i))
                            word_d[i*BYTE_W +: BYTE_W] = byte_data;
                    end
                    byte_idx_d = byte_idx_q + IDX_W'(1);
                end
                if (byte_idx_d == IDX_FULL)
                    state_d = ST_PUSH;
                // Same-cycle byte counts toward the flushed word; a full word still pushes once.
                if (flush_req) begin
                    if (byte_idx_d != '0) begin
                        state_d      = ST_PUSH;
                        flush_pend_d = 1'b1;
                    end else begin
                        flush_done_d = 1'b1;
                    end
                end
            end
            ST_PUSH: begin
                if (flush_req)
                    flush_pend_d = 1'b1;
                if (push) begin
                    state_d      = ST_FILL;
                    word_d       = '0;
                    byte_idx_d   = '0;
                    flush_pend_d = 1'b0;
                    flush_done_d = flush_pend_q || flush_req;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge pkr_clk) begin
        if (pkr_rst) begin
            state_q      <= ST_FILL;
            word_q       <= '0;
            byte_idx_q   <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign byte_ready   = (state_q == ST_FILL);
    assign fifo_wr_en   = push;
    assign fifo_wr_data = word_q;
    assign flush_done   = flush_done_q;
    assign busy         = (byte_idx_q != '0) || (state_q == ST_PUSH) || flush_pend_q;

`ifdef QF_SFF_PKR_WORD_CNT_EN
    always_ff @(posedge pkr_clk) begin
        if (pkr_rst)
            word_cnt <= '0;
        else if (push)
            word_cnt <= word_cnt + WORD_CNT_W'(1);
    end
`endif

endmodule
